// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Used by fifo_rr_pick and fifo_wr_arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Grant-index width; at least one bit, even for a degenerate single requester.
    function automatic int id_width(input int nreq);
        return (nreq > 1) ? $clog2(nreq) : 1;
    endfunction

    // burst_cnt must hold BURST-1 and never wraps within a grant.
    function automatic int cnt_width(input int burst);
        return $clog2(burst) + 1;
    endfunction

endpackage

// File: rtl/fifo_rr_pick.sv
// Combinational rotating priority encoder. It returns the first set request
// found by searching upward from (last+1) mod NREQ, wrapping at NREQ.
module fifo_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IW   = id_width(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   last,
    output logic            found,
    output logic [IW-1:0]   index
);

    int            pos;
    logic [IW-1:0] cand;

    always_comb begin
        // NOTE: every variable written here gets a default first, so no latch is inferred.
        found = 1'b0;
        index = '0;
        pos   = 0;
        cand  = '0;
        // Scan from the farthest offset down, so the nearest candidate is written last and wins.
        for (int k = NREQ; k >= 1; k--) begin
            pos  = (int'(last) + k) % NREQ;
            cand = IW'(pos);
            if (req[cand]) begin
                found = 1'b1;
                index = cand;
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter that shares the FIFO write port among NREQ requesters in bursts of up to BURST words.
// The optional stall counter output is enabled by defining FIFO_ARB_STATS_EN.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter  int DATASIZE = 3,
    parameter  int NREQ     = 4,
    parameter  int BURST    = 4,
    localparam int IW       = id_width(NREQ),
    localparam int CW       = cnt_width(BURST)
) (
    input  logic                     wclk,
    input  logic                     wrst,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*DATASIZE-1:0] req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     wfull,
    output logic                     winc,
    output logic [DATASIZE-1:0]      wdata,
    output logic [IW-1:0]            grant_id,
    output logic                     busy
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]              stall_cnt
`endif
);

    arb_state_t          state, state_nxt;
    logic [IW-1:0]       owner, owner_nxt;
    logic [IW-1:0]       last, last_nxt;
    logic [CW-1:0]       burst_cnt, cnt_nxt;
    logic                pick_found;
    logic [IW-1:0]       pick_idx;
    logic                owner_valid;
    logic                xfer;
    logic [DATASIZE-1:0] slot [NREQ];

    for (genvar g = 0; g < NREQ; g++) begin : g_slot
        assign slot[g] = req_data[g*DATASIZE +: DATASIZE];
    end

    fifo_rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_pick (
        .req   (req_valid),
        .last  (last),
        .found (pick_found),
        .index (pick_idx)
    );

    assign owner_valid = req_valid[owner];
    assign wdata       = slot[owner];
    assign grant_id    = owner;
    assign busy        = (state == GRANT);

    always_comb begin
        state_nxt = state;
        owner_nxt = owner;
        last_nxt  = last;
        cnt_nxt   = burst_cnt;
        req_ready = '0;
        winc      = 1'b0;
        xfer      = 1'b0;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    owner_nxt = pick_idx;
                    cnt_nxt   = '0;
                    state_nxt = GRANT;
                end
            end
            GRANT: begin
                req_ready[owner] = !wfull;
                xfer             = owner_valid && !wfull;
                winc             = xfer;
                if (!owner_valid || (xfer && burst_cnt == CW'(BURST - 1))) begin
                    last_nxt  = owner;
                    state_nxt = IDLE;
                end else if (xfer) begin
                    cnt_nxt = burst_cnt + 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // Handshakes are suppressed while reset is held, so a reset mid-burst never writes a partial word.
        if (wrst) begin
            req_ready = '0;
            winc      = 1'b0;
        end
    end

    always_ff @(posedge wclk) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (wrst) begin
            state     <= IDLE;
            owner     <= '0;
            last      <= IW'(NREQ - 1);
            burst_cnt <= '0;
        end else begin
            state     <= state_nxt;
            owner     <= owner_nxt;
            last      <= last_nxt;
            burst_cnt <= cnt_nxt;
        end
    end

`ifdef FIFO_ARB_STATS_EN
    // Counts cycles in which the owner is blocked by a full FIFO; saturates at all-ones.
    always_ff @(posedge wclk) begin
        if (wrst) begin
            stall_cnt <= '0;
        end else if (state == GRANT && owner_valid && wfull && stall_cnt != 16'hFFFF) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: a scoreboard of expected (owner, word) writes
// checked by independent monitors, plus directed timing checks. Also covers FIFO_ARB_STATS_EN builds.
module tb_fifo_wr_arbiter;

    typedef struct packed {
        logic [1:0] id;
        logic [2:0] data;
    } exp_t;

    logic wclk = 1'b0;
    always #5 wclk = ~wclk;

    // Main instance: DATASIZE=3, NREQ=4, BURST=4.
    logic        wrst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [11:0] req_data;
    logic        wfull;
    logic        winc;
    logic [2:0]  wdata;
    logic [1:0]  grant_id;
    logic        busy;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] stall_cnt;
`endif

    // Second instance: NREQ=2, BURST=1.
    logic        b_wrst;
    logic [1:0]  b_valid;
    logic [1:0]  b_ready;
    logic [5:0]  b_data;
    logic        b_winc;
    logic [2:0]  b_wdata;
    logic        b_gid;
    logic        b_busy;
`ifdef FIFO_ARB_STATS_EN
    logic [15:0] b_stall_cnt;
`endif

    // Requester model: lim[i] words still to send, wseq[i] the next word value.
    int         lim [4];
    logic [2:0] wseq [4];
    exp_t       sb [$];
    exp_t       b_sb [$];
    exp_t       e_a, e_b;
    int         total = 0;
    int         bad   = 0;
    logic [3:0] acc;
    logic [3:0] s_ready;
    logic       s_winc, s_busy, s_bwinc;
    logic [15:0] wp, bp;

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            req_valid[i]         = (lim[i] != 0);
            req_data[i*3 +: 3]   = wseq[i];
        end
    end

    fifo_wr_arbiter #(.DATASIZE(3), .NREQ(4), .BURST(4)) dut (
        .wclk      (wclk),
        .wrst      (wrst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .wfull     (wfull),
        .winc      (winc),
        .wdata     (wdata),
        .grant_id  (grant_id),
        .busy      (busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    fifo_wr_arbiter #(.DATASIZE(3), .NREQ(2), .BURST(1)) dut_b (
        .wclk      (wclk),
        .wrst      (b_wrst),
        .req_valid (b_valid),
        .req_data  (b_data),
        .req_ready (b_ready),
        .wfull     (1'b0),
        .winc      (b_winc),
        .wdata     (b_wdata),
        .grant_id  (b_gid),
        .busy      (b_busy)
`ifdef FIFO_ARB_STATS_EN
        ,
        .stall_cnt (b_stall_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", name, got, exp);
        end
    endtask

    task automatic push(input int id, input int d);
        sb.push_back({2'(id), 3'(d)});
    endtask

    // Monitor for the main instance: protocol rules every cycle, scoreboard on each write.
    always @(negedge wclk) begin
        if (!wrst) begin
            check("ready_onehot", 32'($onehot0(req_ready)), 32'd1);
            check("ready_owner", 32'(req_ready & ~(busy ? (4'b0001 << grant_id) : 4'b0000)), 32'd0);
            if (winc) begin
                check("winc_while_full", 32'(wfull), 32'd0);
                check("sb_has_entry", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    e_a = sb.pop_front();
                    check("write_id_data", 32'({grant_id, wdata}), 32'({e_a.id, e_a.data}));
                end
            end
        end
    end

    // Monitor for the BURST=1 instance.
    always @(negedge wclk) begin
        if (!b_wrst) begin
            check("b_ready_onehot", 32'($onehot0(b_ready)), 32'd1);
            if (b_winc) begin
                check("b_sb_has_entry", 32'(b_sb.size() != 0), 32'd1);
                if (b_sb.size() != 0) begin
                    e_b = b_sb.pop_front();
                    check("b_write_id_data", 32'({b_gid, b_wdata}), 32'({e_b.id[0], e_b.data}));
                end
            end
        end
    end

    // One cycle: sample at the falling edge, then advance the requester model just after the rising edge.
    task automatic tick();
        @(negedge wclk);
        acc     = req_valid & req_ready;
        s_ready = req_ready;
        s_winc  = winc;
        s_busy  = busy;
        s_bwinc = b_winc;
        @(posedge wclk);
        #1;
        for (int i = 0; i < 4; i++) begin
            if (acc[i]) begin
                lim[i]  = lim[i] - 1;
                wseq[i] = wseq[i] + 3'd1;
            end
        end
    endtask

    task automatic run_pat(input int n, output logic [15:0] w, output logic [15:0] b);
        w = '0;
        b = '0;
        repeat (n) begin
            tick();
            w = {w[14:0], s_winc};
            b = {b[14:0], s_busy};
        end
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (((lim[0] | lim[1] | lim[2] | lim[3]) != 0 || busy) && n < 300) begin
            tick();
            n++;
        end
        check({name, "_timeout"}, 32'(n < 300), 32'd1);
        check({name, "_sb_empty"}, 32'(sb.size()), 32'd0);
    endtask

    task automatic do_reset();
        wrst  = 1'b1;
        wfull = 1'b0;
        for (int i = 0; i < 4; i++) begin
            lim[i]  = 0;
            wseq[i] = 3'd0;
        end
        sb.delete();
        tick();
        tick();
        check("rst_busy", 32'(s_busy), 32'd0);
        check("rst_winc", 32'(s_winc), 32'd0);
        check("rst_ready", 32'(s_ready), 32'd0);
        check("rst_grant_id", 32'(grant_id), 32'd0);
`ifdef FIFO_ARB_STATS_EN
        check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
`endif
        wrst = 1'b0;
    endtask

    initial begin
        b_wrst  = 1'b1;
        b_valid = 2'b00;
        b_data  = {3'd5, 3'd2};

        // Single requester holding valid: two 4-word bursts separated by one bubble.
        do_reset();
        lim[0] = 8;
        for (int k = 0; k < 8; k++) push(0, k);
        run_pat(11, wp, bp);
        check("t1_winc_pattern", 32'(wp), 32'h03DE);
        check("t1_busy_pattern", 32'(bp), 32'h03DE);
        drain("t1");

        // All four requesters valid: grant order 0,1,2,3,0.
        do_reset();
        lim[0] = 8;
        lim[1] = 4;
        lim[2] = 4;
        lim[3] = 4;
        for (int k = 0; k < 4; k++) push(0, k);
        for (int k = 0; k < 4; k++) push(1, k);
        for (int k = 0; k < 4; k++) push(2, k);
        for (int k = 0; k < 4; k++) push(3, k);
        for (int k = 4; k < 8; k++) push(0, k);
        drain("t2");

        // Owner 2 stalled by wfull for 5 cycles after two words.
        do_reset();
        lim[2] = 4;
        for (int k = 0; k < 4; k++) push(2, k);
        tick();
        tick();
        tick();
        wfull = 1'b1;
        repeat (5) begin
            tick();
            check("t3_stall_winc", 32'(s_winc), 32'd0);
            check("t3_stall_ready", 32'(s_ready), 32'd0);
            check("t3_stall_busy", 32'(s_busy), 32'd1);
        end
        wfull = 1'b0;
        drain("t3");
`ifdef FIFO_ARB_STATS_EN
        check("t3_stall_cnt", 32'(stall_cnt), 32'd5);
`endif

        // Owner 1 drops valid after 2 words; next grants go 3 then wrap to 0.
        do_reset();
        lim[1] = 2;
        tick();
        check("t4_first_idle_busy", 32'(s_busy), 32'd0);
        lim[0] = 1;
        lim[3] = 1;
        push(1, 0);
        push(1, 1);
        push(3, 0);
        push(0, 0);
        run_pat(10, wp, bp);
        check("t4_winc_pattern", 32'(wp), 32'h0324);
        check("t4_busy_pattern", 32'(bp), 32'h03B6);
        drain("t4");

        // Reset mid-burst on owner 3; requester 0 gets first priority afterwards.
        do_reset();
        lim[3] = 6;
        push(3, 0);
        push(3, 1);
        push(0, 0);
        for (int k = 2; k < 6; k++) push(3, k);
        tick();
        tick();
        tick();
        wrst = 1'b1;
        tick();
        check("t5_rst_winc", 32'(s_winc), 32'd0);
        check("t5_rst_ready", 32'(s_ready), 32'd0);
        wrst   = 1'b0;
        lim[0] = 1;
        tick();
        check("t5_idle_busy", 32'(s_busy), 32'd0);
        check("t5_idle_winc", 32'(s_winc), 32'd0);
        check("t5_restart_owner", 32'(grant_id), 32'd0);
        drain("t5");

        // BURST=1, NREQ=2: grants alternate 0,1,0,1 with a bubble between each.
        b_wrst  = 1'b0;
        b_valid = 2'b11;
        for (int k = 0; k < 2; k++) begin
            b_sb.push_back({2'd0, 3'd2});
            b_sb.push_back({2'd1, 3'd5});
        end
        wp = '0;
        repeat (8) begin
            tick();
            wp = {wp[14:0], s_bwinc};
        end
        b_valid = 2'b00;
        check("t6_winc_pattern", 32'(wp), 32'h0055);
        tick();
        tick();
        check("t6_sb_empty", 32'(b_sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got=time_limit expected=finish");
        $fatal(1, "simulation time limit exceeded");
    end

endmodule
